// File: rtl/bilinear_seq_core.sv
// Sequential bilinear image scaler: one output pixel per 7 cycles, four taps
// fetched from the input BRAM, interpolated and written to the output BRAM.
module bilinear_seq_core #(
    parameter int unsigned AW = 12
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    input  logic          start_pulse,
    input  logic [15:0]   cfg_in_w,
    input  logic [15:0]   cfg_in_h,
    input  logic [15:0]   cfg_scale_q88,
    output logic          status_done,
    output logic          status_busy,
    output logic          status_err,
    output logic [AW-1:0] in_mem_raddr,
    input  logic [7:0]    in_mem_rdata,
    output logic          out_mem_we,
    output logic [AW-1:0] out_mem_waddr,
    output logic [7:0]    out_mem_wdata
);
    localparam int unsigned CW = AW + 1;
    localparam logic [47:0] MAX_AREA = 48'(1) << AW;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_DIV, S_FETCH, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t        state, state_d;
    logic          start_q;
    logic [15:0]   in_w, in_h, scale;
    logic [CW-1:0] out_w, out_h, x, y;
    logic          last_pix;
    logic [15:0]   div_rem;
    logic [16:0]   div_q;
    logic [4:0]    div_cnt;
    logic [2:0]    fcnt;
    logic [7:0]    p00, p01, p10, p11;

    logic          done_d, busy_d, err_d, we_d;
    logic [AW-1:0] waddr_d, raddr_d;
    logic [7:0]    wdata_d;

    // Clamped integer tap pair plus fraction along one axis: {c0, c1, frac}
    function automatic logic [39:0] axis(input logic [47:0] s, input logic [15:0] n);
        logic [15:0] lim, c0, c1;
        logic [7:0]  f;
        lim = n - 16'd1;
        if ((s >> 8) > 48'(lim)) begin
            c0 = lim;
            f  = 8'd0;
        end else begin
            c0 = s[23:8];
            f  = s[7:0];
        end
        c1 = (c0 == lim) ? lim : c0 + 16'd1;
        return {c0, c1, f};
    endfunction

    function automatic logic [AW-1:0] lin(input logic [15:0] r, input logic [15:0] c,
                                          input logic [15:0] w);
        return AW'(32'(r) * 32'(w) + 32'(c));
    endfunction

    // Configuration checks
    logic [31:0] ow_prod, oh_prod;
    logic [23:0] ow_full, oh_full;
    logic [47:0] in_area, out_area;
    logic        cfg_err;
    always_comb begin
        ow_prod  = 32'(in_w) * 32'(scale);
        oh_prod  = 32'(in_h) * 32'(scale);
        ow_full  = 24'(ow_prod >> 8);
        oh_full  = 24'(oh_prod >> 8);
        in_area  = 48'(in_w) * 48'(in_h);
        out_area = 48'(ow_full) * 48'(oh_full);
        cfg_err  = (in_w == 16'd0) || (in_h == 16'd0) || (scale == 16'd0) ||
                   (ow_full == 24'd0) || (oh_full == 24'd0) ||
                   (in_area > MAX_AREA) || (out_area > MAX_AREA);
    end

    // Restoring divider step for 65536 / scale
    logic [16:0] rem_sh;
    logic        div_ge;
    logic [15:0] rem_n;
    always_comb begin
        rem_sh = {div_rem, div_q[16]};
        div_ge = rem_sh >= 17'(scale);
        rem_n  = div_ge ? 16'(rem_sh - 17'(scale)) : rem_sh[15:0];
    end

    // Source coordinates of the current output pixel
    logic [47:0] sx, sy;
    logic [15:0] x0, x1, y0, y1;
    logic [7:0]  fx, fy;
    assign sx = 48'(x) * 48'(div_q);
    assign sy = 48'(y) * 48'(div_q);
    assign {x0, x1, fx} = axis(sx, in_w);
    assign {y0, y1, fy} = axis(sy, in_h);

    // Bilinear blend, exact until the final rounding shift
    logic [31:0] top, bot, blend, pix_shr;
    logic [7:0]  pix;
    always_comb begin
        top     = 32'(p00) * 32'(9'd256 - 9'(fx)) + 32'(p01) * 32'(fx);
        bot     = 32'(p10) * 32'(9'd256 - 9'(fx)) + 32'(p11) * 32'(fx);
        blend   = top * 32'(9'd256 - 9'(fy)) + bot * 32'(fy) + 32'd32768;
        pix_shr = blend >> 16;
        pix     = (pix_shr > 32'd255) ? 8'hFF : pix_shr[7:0];
    end

    logic start_edge, x_last, y_last;
    logic [2:0] tap_k;
    logic [AW-1:0] tap_addr;
    assign start_edge = start_pulse & ~start_q;
    assign x_last     = (x == out_w - CW'(1));
    assign y_last     = (y == out_h - CW'(1));
    assign tap_k      = (state == S_FETCH) ? fcnt + 3'd1 : 3'd0;

    always_comb begin
        case (tap_k[1:0])
            2'd0:    tap_addr = lin(y0, x0, in_w);
            2'd1:    tap_addr = lin(y0, x1, in_w);
            2'd2:    tap_addr = lin(y1, x0, in_w);
            default: tap_addr = lin(y1, x1, in_w);
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state;
        err_d   = status_err;
        we_d    = 1'b0;
        waddr_d = out_mem_waddr;
        wdata_d = out_mem_wdata;
        raddr_d = in_mem_raddr;
        case (state)
            S_IDLE, S_DONE: if (start_edge) begin
                state_d = S_SETUP;
                err_d   = 1'b0;
            end
            S_SETUP: if (cfg_err) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                state_d = S_DIV;
            end
            S_DIV:   if (div_cnt == 5'd16) state_d = S_FETCH;
            S_FETCH: if (fcnt == 3'd4) state_d = S_CALC;
            S_CALC: begin
                state_d = S_WRITE;
                we_d    = 1'b1;
                waddr_d = AW'(32'(y) * 32'(out_w) + 32'(x));
                wdata_d = pix;
            end
            S_WRITE: state_d = last_pix ? S_DONE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
        // Address is registered one cycle ahead so it is on the bus during its fetch cycle
        if (state_d == S_FETCH && tap_k < 3'd4) raddr_d = tap_addr;
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state         <= S_IDLE;
            status_done   <= 1'b0;
            status_busy   <= 1'b0;
            status_err    <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_waddr <= '0;
            out_mem_wdata <= '0;
            in_mem_raddr  <= '0;
        end else begin
            state         <= state_d;
            status_done   <= done_d;
            status_busy   <= busy_d;
            status_err    <= err_d;
            out_mem_we    <= we_d;
            out_mem_waddr <= waddr_d;
            out_mem_wdata <= wdata_d;
            in_mem_raddr  <= raddr_d;
        end
    end

    // Datapath registers; start_q resets high so a level held through reset is not an edge
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            start_q  <= 1'b1;
            in_w     <= '0;
            in_h     <= '0;
            scale    <= '0;
            out_w    <= '0;
            out_h    <= '0;
            x        <= '0;
            y        <= '0;
            last_pix <= 1'b0;
            div_rem  <= '0;
            div_q    <= '0;
            div_cnt  <= '0;
            fcnt     <= '0;
            p00      <= '0;
            p01      <= '0;
            p10      <= '0;
            p11      <= '0;
        end else begin
            start_q <= start_pulse;
            case (state)
                S_IDLE, S_DONE: if (start_edge) begin
                    in_w  <= cfg_in_w;
                    in_h  <= cfg_in_h;
                    scale <= cfg_scale_q88;
                end
                S_SETUP: begin
                    out_w    <= CW'(ow_full);
                    out_h    <= CW'(oh_full);
                    x        <= '0;
                    y        <= '0;
                    last_pix <= 1'b0;
                    div_rem  <= '0;
                    div_q    <= 17'h10000;
                    div_cnt  <= '0;
                end
                S_DIV: begin
                    div_rem <= rem_n;
                    div_q   <= {div_q[15:0], div_ge};
                    div_cnt <= div_cnt + 5'd1;
                    fcnt    <= '0;
                end
                S_FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    case (fcnt)
                        3'd1:    p00 <= in_mem_rdata;
                        3'd2:    p01 <= in_mem_rdata;
                        3'd3:    p10 <= in_mem_rdata;
                        3'd4:    p11 <= in_mem_rdata;
                        default: ;
                    endcase
                end
                S_CALC: begin
                    fcnt     <= '0;
                    last_pix <= x_last && y_last;
                    if (x_last) begin
                        x <= '0;
                        y <= y + CW'(1);
                    end else begin
                        x <= x + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bilinear_seq_core.sv
// Self-checking bench for bilinear_seq_core: vector table, random jobs against
// an arithmetic reference model, and hand-written start/reset sequences.
module tb_bilinear_seq_core;
    localparam int AW     = 12;
    localparam int BUDGET = 40000;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic          start_pulse = 1'b0;
    logic [15:0]   cfg_in_w = '0, cfg_in_h = '0, cfg_scale_q88 = '0;
    logic          status_done, status_busy, status_err;
    logic [AW-1:0] in_mem_raddr, out_mem_waddr;
    logic [7:0]    in_mem_rdata, out_mem_wdata;
    logic          out_mem_we;

    always #5 clk_sys = ~clk_sys;

    bilinear_seq_core #(.AW(AW)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_pulse(start_pulse),
        .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
        .status_done(status_done), .status_busy(status_busy), .status_err(status_err),
        .in_mem_raddr(in_mem_raddr), .in_mem_rdata(in_mem_rdata),
        .out_mem_we(out_mem_we), .out_mem_waddr(out_mem_waddr), .out_mem_wdata(out_mem_wdata)
    );

    logic [7:0] in_mem [4096];
    always @(posedge clk_sys) in_mem_rdata <= in_mem[in_mem_raddr];

    int     wr_addr[$];
    int     wr_data[$];
    longint wr_cyc[$];
    longint cyc_no = 0;
    always @(posedge clk_sys) begin
        cyc_no <= cyc_no + 1;
        if (out_mem_we === 1'b1) begin
            wr_addr.push_back(int'(out_mem_waddr));
            wr_data.push_back(int'(out_mem_wdata));
            wr_cyc.push_back(cyc_no);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Reference: straight from the scaling rules, in plain integer arithmetic
    function automatic bit model_err(int w, int h, int s);
        longint ow, oh;
        ow = (longint'(w) * s) / 256;
        oh = (longint'(h) * s) / 256;
        return (w == 0) || (h == 0) || (s == 0) || (ow == 0) || (oh == 0) ||
               (longint'(w) * h > 4096) || (ow * oh > 4096);
    endfunction

    function automatic int model_pix(int w, int h, int s, int x, int y);
        int inv, sx, sy, ix, iy, x0, x1, y0, y1, fx, fy;
        longint top, bot, v;
        inv = 65536 / s;
        sx = x * inv;  sy = y * inv;
        ix = sx / 256; iy = sy / 256;
        x0 = (ix > w - 1) ? w - 1 : ix;
        y0 = (iy > h - 1) ? h - 1 : iy;
        x1 = (x0 + 1 > w - 1) ? w - 1 : x0 + 1;
        y1 = (y0 + 1 > h - 1) ? h - 1 : y0 + 1;
        fx = (x0 == ix) ? sx % 256 : 0;
        fy = (y0 == iy) ? sy % 256 : 0;
        top = longint'(in_mem[y0*w + x0]) * (256 - fx) + longint'(in_mem[y0*w + x1]) * fx;
        bot = longint'(in_mem[y1*w + x0]) * (256 - fx) + longint'(in_mem[y1*w + x1]) * fx;
        v = (top * (256 - fy) + bot * fy + 32768) / 65536;
        return (v > 255) ? 255 : int'(v);
    endfunction

    task automatic wait_done(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        while (lat < BUDGET) begin
            if (status_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
            lat++;
        end
    endtask

    // One-cycle start; cfg is scrambled afterwards to show it was latched
    task automatic run_job(input int w, input int h, input int s, output int lat, output bit ok);
        clear_log();
        @(negedge clk_sys);
        cfg_in_w = 16'(w); cfg_in_h = 16'(h); cfg_scale_q88 = 16'(s);
        start_pulse = 1'b1;
        @(negedge clk_sys);
        start_pulse = 1'b0;
        cfg_in_w = 16'hFFFF; cfg_in_h = 16'h0001; cfg_scale_q88 = 16'h0000;
        wait_done(lat, ok);
    endtask

    task automatic verify_job(input string name, input int w, input int h, input int s,
                              input bit exp_err, input int exp_n, input int lat, input bit ok);
        int ow, n, bad_gap;
        check({name, "_done_seen"}, ok, 1);
        check({name, "_err"}, status_err, exp_err);
        check({name, "_busy"}, status_busy, 0);
        check({name, "_nwrites"}, wr_addr.size(), exp_n);
        if (exp_err) begin
            check({name, "_err_latency_le3"}, (lat <= 3), 1);
        end else begin
            ow = (w * s) / 256;
            n = (wr_addr.size() < exp_n) ? wr_addr.size() : exp_n;
            bad_gap = 0;
            for (int i = 0; i < n; i++) begin
                check({name, "_addr"}, wr_addr[i], i);
                check({name, "_pix"}, wr_data[i], model_pix(w, h, s, i % ow, i / ow));
                if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 7) bad_gap++;
            end
            check({name, "_gap7"}, bad_gap, 0);
        end
    endtask

    typedef struct {
        int w;
        int h;
        int s;
        bit err;
        int n;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   lat, w, h, s, n;
        bit   ok, e;
        int   row0[4];

        vecs[0]  = '{4, 4, 256, 1'b0, 16};
        vecs[1]  = '{3, 5, 384, 1'b0, 28};
        vecs[2]  = '{5, 3, 200, 1'b0, 6};
        vecs[3]  = '{7, 6, 300, 1'b0, 56};
        vecs[4]  = '{64, 64, 64, 1'b0, 256};
        vecs[5]  = '{32, 32, 512, 1'b0, 4096};
        vecs[6]  = '{65, 64, 256, 1'b1, 0};
        vecs[7]  = '{33, 32, 512, 1'b1, 0};
        vecs[8]  = '{1, 1, 128, 1'b1, 0};
        vecs[9]  = '{0, 4, 256, 1'b1, 0};
        vecs[10] = '{4, 4, 0, 1'b1, 0};
        vecs[11] = '{4, 0, 256, 1'b1, 0};
        row0 = '{0, 50, 100, 100};
        for (int i = 0; i < 4096; i++) in_mem[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_done", status_done, 0);
        check("rst_busy", status_busy, 0);
        check("rst_err", status_err, 0);
        check("rst_we", out_mem_we, 0);
        check("rst_raddr", in_mem_raddr, 0);
        rst_sys_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Identity
        for (int i = 0; i < 16; i++) in_mem[i] = 8'(i);
        run_job(4, 4, 256, lat, ok);
        check("id_done", status_done, 1);
        check("id_nwrites", wr_data.size(), 16);
        for (int i = 0; i < 16 && i < wr_data.size(); i++) check("id_pix", wr_data[i], i);

        // Upscale 2x2 -> 4x4
        in_mem[0] = 8'd0; in_mem[1] = 8'd100; in_mem[2] = 8'd200; in_mem[3] = 8'd255;
        run_job(2, 2, 512, lat, ok);
        check("up_nwrites", wr_data.size(), 16);
        if (wr_data.size() == 16) begin
            for (int i = 0; i < 4; i++) check("up_row0", wr_data[i], row0[i]);
            check("up_last", wr_data[15], 255);
            for (int i = 1; i < 16; i++) check("up_gap", wr_cyc[i] - wr_cyc[i-1], 7);
        end

        // Vector table
        for (int v = 0; v < 12; v++) begin
            n = vecs[v].w * vecs[v].h;
            for (int i = 0; i < n && i < 4096; i++) in_mem[i] = 8'($urandom_range(0, 255));
            run_job(vecs[v].w, vecs[v].h, vecs[v].s, lat, ok);
            verify_job($sformatf("vec%0d", v), vecs[v].w, vecs[v].h, vecs[v].s,
                       vecs[v].err, vecs[v].n, lat, ok);
        end

        // Random jobs against the model
        for (int r = 0; r < 5; r++) begin
            w = $urandom_range(1, 10);
            h = $urandom_range(1, 10);
            s = $urandom_range(64, 600);
            for (int i = 0; i < w * h; i++) in_mem[i] = 8'($urandom_range(0, 255));
            e = model_err(w, h, s);
            n = e ? 0 : ((w * s) / 256) * ((h * s) / 256);
            run_job(w, h, s, lat, ok);
            verify_job($sformatf("rnd%0d_%0dx%0d_s%0d", r, w, h, s), w, h, s, e, n, lat, ok);
        end

        // Long start pulse plus a second edge while busy: exactly one job
        for (int i = 0; i < 16; i++) in_mem[i] = 8'(i);
        clear_log();
        @(negedge clk_sys);
        cfg_in_w = 16'd4; cfg_in_h = 16'd4; cfg_scale_q88 = 16'd256;
        start_pulse = 1'b1;
        repeat (8) @(negedge clk_sys);
        check("long_start_busy", status_busy, 1);
        start_pulse = 1'b0;
        repeat (3) @(negedge clk_sys);
        start_pulse = 1'b1;
        repeat (2) @(negedge clk_sys);
        start_pulse = 1'b0;
        wait_done(lat, ok);
        check("long_start_done_seen", ok, 1);
        repeat (30) @(negedge clk_sys);
        check("long_start_nwrites", wr_data.size(), 16);
        check("long_start_done_held", status_done, 1);

        // New start after DONE clears done and reruns
        clear_log();
        start_pulse = 1'b1;
        @(negedge clk_sys);
        start_pulse = 1'b0;
        check("rerun_done_cleared", status_done, 0);
        check("rerun_busy", status_busy, 1);
        wait_done(lat, ok);
        check("rerun_done_seen", ok, 1);
        check("rerun_nwrites", wr_data.size(), 16);

        // Reset in the middle of a job
        run_job(4, 4, 0, lat, ok);
        clear_log();
        @(negedge clk_sys);
        cfg_in_w = 16'd4; cfg_in_h = 16'd4; cfg_scale_q88 = 16'd256;
        start_pulse = 1'b1;
        @(negedge clk_sys);
        start_pulse = 1'b0;
        n = 0;
        while (wr_addr.size() < 2 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check("mid_reached_fetch", (wr_addr.size() >= 2), 1);
        rst_sys_n = 1'b0;
        start_pulse = 1'b1;
        #1;
        check("mid_rst_done", status_done, 0);
        check("mid_rst_busy", status_busy, 0);
        check("mid_rst_err", status_err, 0);
        check("mid_rst_we", out_mem_we, 0);
        check("mid_rst_waddr", out_mem_waddr, 0);
        check("mid_rst_wdata", out_mem_wdata, 0);
        check("mid_rst_raddr", in_mem_raddr, 0);
        n = wr_addr.size();
        repeat (3) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("held_start_no_writes", wr_addr.size(), n);
        check("held_start_idle", status_busy, 0);
        start_pulse = 1'b0;
        run_job(4, 4, 256, lat, ok);
        check("post_rst_done_seen", ok, 1);
        check("post_rst_nwrites", wr_data.size(), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bilinear_seq_core.md
BILINEAR_SEQ_CORE -- requirements
Module: bilinear_seq_core

Interface
REQ-001 SHALL have parameter AW, default 12, giving the address width of both image BRAMs.
REQ-002 SHALL have ports:
- clk_sys, input, 1: single system clock; all logic on its rising edge.
- rst_sys_n, input, 1: asynchronous active-low reset.
- start_pulse, input, 1: start request, possibly several cycles wide.
- cfg_in_w, input, 16: input image width.
- cfg_in_h, input, 16: input image height.
- cfg_scale_q88, input, 16: scale factor, unsigned Q8.8.
- status_done, output, 1: job finished (level).
- status_busy, output, 1: job in progress.
- status_err, output, 1: last job rejected its configuration.
- in_mem_raddr, output, AW: input BRAM read address.
- in_mem_rdata, input, 8: input BRAM data; 1-cycle read latency.
- out_mem_we, output, 1: output BRAM write enable.
- out_mem_waddr, output, AW: output BRAM write address.
- out_mem_wdata, output, 8: output BRAM write data.

Function
REQ-003 SHALL start a job only on a rising edge of start_pulse seen while state is IDLE or DONE; edges during any other state SHALL be ignored.
REQ-004 SHALL latch cfg_in_w, cfg_in_h and cfg_scale_q88 on the start cycle; later changes to them SHALL NOT affect the running job.
REQ-005 SHALL clear status_done and status_err on an accepted start.
REQ-006 SHALL implement the states IDLE -> SETUP -> DIV -> PIX_FETCH -> PIX_CALC -> PIX_WRITE -> (loop to PIX_FETCH or go to DONE), plus SETUP -> DONE on error.
REQ-007 SETUP (1 cycle) SHALL compute out_w = (in_w*scale)>>8 and out_h = (in_h*scale)>>8, using full-width 32-bit products.
REQ-008 SETUP SHALL flag an error and go to DONE with status_err=1 and no writes if any of these hold: in_w=0, in_h=0, scale=0, out_w=0, out_h=0, in_w*in_h > 2^AW, or out_w*out_h > 2^AW.
REQ-009 DIV SHALL compute inv = floor(65536/scale), 17-bit unsigned Q8.8, with a restoring divider taking exactly 17 cycles.
REQ-010 Pixels SHALL be scanned in raster order, x fastest, y from 0 to out_h-1 and x from 0 to out_w-1.
REQ-011 For each output pixel:
- sx = x*inv, sy = y*inv (Q8.8).
- x0 = min(sx>>8, in_w-1); x1 = min(x0+1, in_w-1).
- y0 and y1 are derived from sy the same way, clamped to in_h-1.
- fx = sx[7:0] if x0 = sx>>8, else 0; fy likewise.
REQ-012 PIX_FETCH SHALL take 5 cycles:
- cycles 0..3 issue in_mem_raddr = y0*in_w+x0, y0*in_w+x1, y1*in_w+x0, y1*in_w+x1, giving p00, p01, p10, p11;
- each datum SHALL be captured on the cycle after its address.
REQ-013 PIX_CALC (1 cycle) SHALL compute the result in exact unsigned arithmetic with no intermediate truncation:
- top = p00*(256-fx) + p01*fx;
- bot = p10*(256-fx) + p11*fx;
- pix = (top*(256-fy) + bot*fy + 32768) >> 16, saturated to 255.
REQ-014 PIX_WRITE SHALL assert out_mem_we for exactly 1 cycle, with out_mem_waddr = y*out_w+x and out_mem_wdata = pix.
REQ-015 Each pixel SHALL therefore take exactly 7 cycles, and out_mem_we SHALL pulse exactly out_w*out_h times per job.
REQ-016 After the last write, the block SHALL enter DONE on the next cycle, with status_done=1 and status_busy=0.
REQ-017 status_done SHALL stay high until the next accepted start or reset.
REQ-018 status_busy SHALL be 1 in states SETUP through PIX_WRITE, and 0 otherwise.
REQ-019 out_mem_we SHALL be 0 in every state except PIX_WRITE.
REQ-020 in_mem_raddr SHALL hold its last value outside PIX_FETCH.

Reset
REQ-021 Asserting rst_sys_n low SHALL take effect immediately, including in the middle of a job:
- state returns to IDLE;
- status_done=0, status_busy=0, status_err=0;
- out_mem_we=0, out_mem_waddr=0, out_mem_wdata=0, in_mem_raddr=0;
- the start edge detector is cleared.
REQ-022 A start_pulse that is already high when reset is released SHALL NOT start a job until it goes low and then rises again.

Verification
REQ-023 Identity: in 4x4 with values 0..15, scale=256 -> inv=256, exactly 16 writes, out[i]=i, status_done=1, status_err=0.
REQ-024 Upscale: in 2x2 = {0,100,200,255}, scale=512 -> inv=128, out 4x4; row0 = 0,50,100,100; out[15]=255; exactly 16 we pulses spaced 7 cycles apart.
REQ-025 Error: scale=0 or in_w=0 -> status_err=1 and status_done=1 within 3 cycles of start, with zero we pulses.
REQ-026 Restart rules:
- an 8-cycle start_pulse starts exactly one job;
- a second start edge while busy is ignored;
- a new start after DONE clears done and reruns.
REQ-027 Reset mid-job: assert rst_sys_n low during PIX_FETCH -> all outputs return to their reset values immediately, and there are no further writes until a new start edge.
